// File: rtl/noc_pkg.sv
// Shared NoC types: VC id, flit preamble and round-robin helper.
// Used by noc_vc_input_buffer and its per-VC FIFO.
package noc;

    localparam int kMaxVcs = 8;
    localparam int kMaxVcW = 3;

    typedef logic [kMaxVcW-1:0] vc_id_t;

    typedef enum logic [1:0] {
        pre_head,
        pre_body,
        pre_tail,
        pre_single
    } preamble_t;

    // First set bit of mask strictly after ptr, wrapping around.
    function automatic vc_id_t rr_next(
        input logic [kMaxVcs-1:0] mask,
        input vc_id_t             ptr
    );
        logic   found;
        vc_id_t idx;
        rr_next = ptr;
        found   = 1'b0;
        for (int i = 1; i <= kMaxVcs; i++) begin
            idx = vc_id_t'((int'(ptr) + i) % kMaxVcs);
            if (!found && mask[idx]) begin
                rr_next = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/noc_vc_input_buffer_fifo.sv
// Single-VC flit FIFO with extra pointer bit for full/empty.
// Push while full is accepted only together with a pop.
module noc_vc_fifo
    import noc::*;
#(
    parameter int Width = 34,
    parameter int Depth = 4,
    localparam int AddrW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wr_data,
    output logic [Width-1:0] data,
    output logic             full,
    output logic             empty,
    output logic [AddrW:0]   count
);

    logic [Width-1:0] mem [Depth];
    logic [AddrW:0]   wr_ptr;
    logic [AddrW:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AddrW-1:0]] <= wr_data;
        end
    end

    assign count = wr_ptr - rd_ptr;
    assign full  = count == (AddrW+1)'(Depth);
    assign empty = count == '0;
    assign data  = mem[rd_ptr[AddrW-1:0]];

endmodule

// File: rtl/noc_vc_input_buffer.sv
// Credit-based multi-VC input unit with round-robin, grant-locked output.
// Optional same-cycle bypass: define NOC_VC_BUFFER_BYPASS_EN.
module noc_vc_input_buffer
    import noc::*;
#(
    parameter int Width  = 34,
    parameter int NumVcs = 2,
    parameter int Depth  = 4,
    localparam int VcW   = (NumVcs > 1) ? $clog2(NumVcs) : 1,
    localparam int CntW  = $clog2(Depth) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [Width-1:0]       data_in,
    input  logic                   data_void_in,
    input  logic [VcW-1:0]         vc_in,
    output logic [NumVcs-1:0]      credit_out,
    output logic [Width-1:0]       out_data,
    output logic [VcW-1:0]         out_vc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NumVcs*CntW-1:0] occupancy,
    output logic                   overflow_err
);

    logic [Width-1:0]   head  [NumVcs];
    logic [CntW-1:0]    count [NumVcs];
    logic [NumVcs-1:0]  full;
    logic [NumVcs-1:0]  empty;
    logic [NumVcs-1:0]  push;
    logic [NumVcs-1:0]  pop;
    logic [NumVcs-1:0]  credit_d;
    logic [NumVcs-1:0]  credit_q;
    logic [kMaxVcs-1:0] mask;
    vc_id_t             rr_ptr;
    vc_id_t             lock_vc;
    vc_id_t             grant;
    logic               lock;
    logic               handshake;
    logic               vc_ok;
    logic               bypass;
    logic               consumed;
    logic               overflow;

    for (genvar v = 0; v < NumVcs; v++) begin : g_vc
        noc_vc_fifo #(
            .Width (Width),
            .Depth (Depth)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push    (push[v]),
            .pop     (pop[v]),
            .wr_data (data_in),
            .data    (head[v]),
            .full    (full[v]),
            .empty   (empty[v]),
            .count   (count[v])
        );
        assign occupancy[v*CntW +: CntW] = count[v];
    end

    always_comb begin
        mask = '0;
        for (int v = 0; v < NumVcs; v++) begin
            mask[v] = ~empty[v];
        end
    end

    assign vc_ok = int'(vc_in) < NumVcs;

`ifdef NOC_VC_BUFFER_BYPASS_EN
    // Only when nothing is buffered anywhere can a new flit skip the FIFO.
    assign bypass = rst & ~data_void_in & vc_ok & ~|mask & ~lock;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        grant = lock ? lock_vc : rr_next(mask, rr_ptr);
        if (bypass) begin
            grant = vc_id_t'(vc_in);
        end
    end

    assign out_valid = |mask | bypass;
    assign handshake = out_valid & out_ready;
    assign consumed  = bypass & out_ready;

    always_comb begin
        out_data = '0;
        out_vc   = '0;
        if (bypass) begin
            out_data = data_in;
            out_vc   = vc_in;
        end else if (out_valid) begin
            out_vc = VcW'(grant);
            for (int v = 0; v < NumVcs; v++) begin
                if (grant == vc_id_t'(v)) begin
                    out_data = head[v];
                end
            end
        end
    end

    always_comb begin
        push     = '0;
        pop      = '0;
        credit_d = '0;
        overflow = ~data_void_in & ~vc_ok;
        for (int v = 0; v < NumVcs; v++) begin
            credit_d[v] = handshake & (grant == vc_id_t'(v));
            pop[v]      = credit_d[v] & ~bypass;
            push[v]     = ~data_void_in & ~consumed
                        & (vc_in == VcW'(v));
            overflow    = overflow
                        | (push[v] & full[v] & ~pop[v]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr       <= vc_id_t'(NumVcs - 1);
            lock         <= 1'b0;
            lock_vc      <= '0;
            credit_q     <= '0;
            overflow_err <= 1'b0;
        end else begin
            credit_q <= credit_d;
            if (overflow) begin
                overflow_err <= 1'b1;
            end
            if (handshake) begin
                rr_ptr <= grant;
                lock   <= 1'b0;
            end else if (out_valid) begin
                lock    <= 1'b1;
                lock_vc <= grant;
            end
        end
    end

    assign credit_out = credit_q;

endmodule
